// File: rtl/cn_pkg.sv
// cn_pkg: shared types and helpers for the serial check-node block.
// Sign-magnitude pack/unpack and saturating offset subtraction.
package cn_pkg;

  localparam int unsigned MW = 32;

  typedef logic [MW-1:0] word_t;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } cn_state_e;

  // w is the full message width; the sign sits at bit w-1.
  function automatic logic sm_sign(
    input word_t       m,
    input int unsigned w
  );
    return m[w-1];
  endfunction

  function automatic word_t sm_mag(
    input word_t       m,
    input int unsigned w
  );
    word_t mask;
    mask = (word_t'(1) << (w - 1)) - word_t'(1);
    return m & mask;
  endfunction

  function automatic word_t sm_pack(
    input logic        s,
    input word_t       mag,
    input int unsigned w
  );
    word_t r;
    r      = mag;
    r[w-1] = s;
    return r;
  endfunction

  function automatic word_t sat_sub(
    input word_t a,
    input word_t b
  );
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/cn_serial_min2.sv
// cn_min2_update: next min1/min2/min1-index given one new magnitude.
// Ports: min1, min2, idx, mag, e_idx in; min1_nx, min2_nx, idx_nx out.
module cn_min2_update #(
  parameter int MAGW = 7,
  parameter int IW   = 3
) (
  input  logic [MAGW-1:0] min1,
  input  logic [MAGW-1:0] min2,
  input  logic [IW-1:0]   idx,
  input  logic [MAGW-1:0] mag,
  input  logic [IW-1:0]   e_idx,
  output logic [MAGW-1:0] min1_nx,
  output logic [MAGW-1:0] min2_nx,
  output logic [IW-1:0]   idx_nx
);

  // Strict compares: a tie with min1 lands in min2 and the
  // first edge holding the minimum keeps the index.
  always_comb begin
    min1_nx = min1;
    min2_nx = min2;
    idx_nx  = idx;
    if (mag < min1) begin
      min2_nx = min1;
      min1_nx = mag;
      idx_nx  = e_idx;
    end else if (mag < min2) begin
      min2_nx = mag;
    end
  end

endmodule

// File: rtl/cn_serial.sv
// cn_serial: serial offset-min-sum check node, one edge per cycle.
// Ports: clk, rst_n; in_valid/in_ready/in_msg; out_valid/out_ready/out_msg/out_idx.
module cn_serial
  import cn_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEG    = 6,
  parameter int OFFSET = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_msg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_msg,
  output logic [$clog2(DEG)-1:0] out_idx
);

  localparam int MAGW = WIDTH - 1;
  localparam int IW   = $clog2(DEG);

  cn_state_e state, state_nx;

  logic [IW-1:0]   cnt;
  logic [MAGW-1:0] min1, min2;
  logic [IW-1:0]   idx;
  logic            tot;
  logic [DEG-1:0]  sgns;

  logic [MAGW-1:0] n_min1, n_min2, in_mag;
  logic [IW-1:0]   n_idx, nxt_idx;
  logic            in_sgn, tot_nx;
  logic            acc, hs, last_in, last_out;

  assign in_mag   = MAGW'(sm_mag(word_t'(in_msg), WIDTH));
  assign in_sgn   = sm_sign(word_t'(in_msg), WIDTH);
  assign tot_nx   = tot ^ in_sgn;
  assign acc      = in_valid & in_ready;
  assign hs       = out_valid & out_ready;
  assign last_in  = (cnt == IW'(DEG - 1));
  assign last_out = (out_idx == IW'(DEG - 1));
  assign nxt_idx  = out_idx + 1'b1;

  cn_min2_update #(
    .MAGW (MAGW),
    .IW   (IW)
  ) u_min2 (
    .min1    (min1),
    .min2    (min2),
    .idx     (idx),
    .mag     (in_mag),
    .e_idx   (cnt),
    .min1_nx (n_min1),
    .min2_nx (n_min2),
    .idx_nx  (n_idx)
  );

  function automatic logic [WIDTH-1:0] mk(
    input logic [MAGW-1:0] m1,
    input logic [MAGW-1:0] m2,
    input logic [IW-1:0]   ix,
    input logic [IW-1:0]   e,
    input logic            s
  );
    word_t mag;
    mag = sat_sub(word_t'((e == ix) ? m2 : m1),
                  word_t'(OFFSET));
    return WIDTH'(sm_pack(s & (mag != '0), mag, WIDTH));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      COLLECT: if (acc && last_in)  state_nx = EMIT;
      EMIT:    if (hs && last_out)  state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_msg   <= '0;
      out_idx   <= '0;
      cnt       <= '0;
      min1      <= '1;
      min2      <= '1;
      idx       <= '0;
      tot       <= 1'b0;
      sgns      <= '0;
    end else begin
      in_ready  <= (state_nx == COLLECT);
      out_valid <= (state_nx == EMIT);
      if (acc) begin
        cnt        <= last_in ? '0 : cnt + 1'b1;
        min1       <= n_min1;
        min2       <= n_min2;
        idx        <= n_idx;
        tot        <= tot_nx;
        sgns[cnt]  <= in_sgn;
        // Edge 0 is built from the frame's final trackers,
        // which include the edge accepted this cycle.
        if (last_in) begin
          out_idx <= '0;
          out_msg <= mk(n_min1, n_min2, n_idx, '0,
                        tot_nx ^ sgns[0]);
        end
      end
      if (hs) begin
        if (last_out) begin
          out_idx <= '0;
          out_msg <= '0;
          min1    <= '1;
          min2    <= '1;
          idx     <= '0;
          tot     <= 1'b0;
          sgns    <= '0;
        end else begin
          out_idx <= nxt_idx;
          out_msg <= mk(min1, min2, idx, nxt_idx,
                        tot ^ sgns[nxt_idx]);
        end
      end
    end
  end

endmodule
